// File: rtl/mips_bus_pkg.sv
// Shared definitions for the mips core to sram-like bus bridge: channel FSM
// states, sram-like size codes and the byte-select to size decoder.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD,
        CANCEL
    } chanState_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic       legal;
        logic [1:0] size;
    } sizeInfo_t;

    // Byte selects come zero-extended to 8 bits so one decoder serves both
    // 32- and 64-bit buses; an unrecognised pattern is reported as not legal.
    function automatic sizeInfo_t sel_to_size(input logic [7:0] sel);
        sizeInfo_t info;
        info.legal = 1'b1;
        if ($countones(sel) == 1) begin
            info.size = SIZE_BYTE;
        end else if (sel inside {8'h03, 8'h0C, 8'h30, 8'hC0}) begin
            info.size = SIZE_HALF;
        end else begin
            info.size  = SIZE_WORD;
            info.legal = sel inside {8'h0F, 8'hF0};
        end
        return info;
    endfunction

endpackage

// File: rtl/mips_sramlike_bridge_chan.sv
// One sram-like channel: turns a level enable from the core into a single
// req/addr_ok/data_ok transaction and holds the result until the pipe advances.
module sramlike_chan
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SIZE_W    = 2,
    parameter bit CANCEL_EN = 1'b0,
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              wr,
    input  logic [STRB_W-1:0] sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    input  logic              longestStall,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              busReq,
    output logic              busWr,
    output logic [SIZE_W-1:0] busSize,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWdata,
    input  logic [DATA_W-1:0] busRdata,
    input  logic              busAddrOk,
    input  logic              busDataOk
);

    chanState_t        state, stateNext;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg, holdReg;
    logic [SIZE_W-1:0] sizeReg;
    logic              wrReg;
    sizeInfo_t         selInfo;
    logic              cancelReq, respDone, capture;

    assign selInfo   = sel_to_size(8'(sel));
    assign cancelReq = CANCEL_EN && flush;
    assign respDone  = busDataOk && ((state == DATA) || (state == ADDR && busAddrOk));
    assign capture   = respDone && !cancelReq;

    // NOTE: every output of this block is assigned before the case so no path leaves one unassigned and infers a latch.
    always_comb begin
        stateNext = state;
        busReq    = (state == ADDR);
        stall     = resetn && en && !cancelReq && !respDone && (state inside {IDLE, ADDR, DATA});
        unique case (state)
            IDLE:   if (en && !cancelReq) stateNext = ADDR;
            ADDR: begin
                // Once the address is accepted the response must still be drained.
                if (cancelReq)      stateNext = (busAddrOk && !busDataOk) ? CANCEL : IDLE;
                else if (respDone)  stateNext = HOLD;
                else if (busAddrOk) stateNext = DATA;
            end
            DATA: begin
                if (busDataOk)      stateNext = cancelReq ? IDLE : HOLD;
                else if (cancelReq) stateNext = CANCEL;
            end
            HOLD:   if (!longestStall) stateNext = IDLE;
            CANCEL: if (busDataOk) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            addrReg  <= '0;
            wdataReg <= '0;
            sizeReg  <= '0;
            wrReg    <= 1'b0;
            holdReg  <= '0;
        end else begin
            state <= stateNext;
            if (state == IDLE && stateNext == ADDR) begin
                addrReg  <= addr;
                wdataReg <= wdata;
                sizeReg  <= SIZE_W'(selInfo.size);
                wrReg    <= wr && selInfo.legal;
            end
            if (capture) holdReg <= busRdata;
        end
    end

    assign rdata    = capture ? busRdata : holdReg;
    assign busWr    = wrReg;
    assign busSize  = sizeReg;
    assign busAddr  = addrReg;
    assign busWdata = wdataReg;

endmodule

// File: rtl/mips_sramlike_bridge.sv
// Bridge between the mips core's per-cycle fetch/data enables and two
// sram-like bus ports; the fetch port can be cancelled by a pipeline flush.
module mips_sramlike_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SIZE_W  = 2,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_inst_en,
    input  logic [ADDR_W-1:0] cpu_inst_addr,
    output logic [DATA_W-1:0] cpu_inst_rdata,
    output logic              cpu_inst_stall,
    input  logic              cpu_data_en,
    input  logic              cpu_data_wr,
    input  logic [STRB_W-1:0] cpu_data_sel,
    input  logic [ADDR_W-1:0] cpu_data_addr,
    input  logic [DATA_W-1:0] cpu_data_wdata,
    output logic [DATA_W-1:0] cpu_data_rdata,
    output logic              cpu_data_stall,
    input  logic              cpu_longest_stall,
    input  logic              cpu_flush,
    output logic              inst_req,
    output logic              inst_wr,
    output logic [SIZE_W-1:0] inst_size,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_wdata,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    output logic              data_req,
    output logic              data_wr,
    output logic [SIZE_W-1:0] data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok
);

    // Fetches are always full, read-only words, so write flag and data stay 0.
    sramlike_chan #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CANCEL_EN(1'b1)
    ) instChan (
        .clk(clk), .resetn(resetn),
        .en(cpu_inst_en), .wr(1'b0), .sel({STRB_W{1'b1}}),
        .addr(cpu_inst_addr), .wdata({DATA_W{1'b0}}),
        .flush(cpu_flush), .longestStall(cpu_longest_stall),
        .rdata(cpu_inst_rdata), .stall(cpu_inst_stall),
        .busReq(inst_req), .busWr(inst_wr), .busSize(inst_size),
        .busAddr(inst_addr), .busWdata(inst_wdata), .busRdata(inst_rdata),
        .busAddrOk(inst_addr_ok), .busDataOk(inst_data_ok)
    );

    sramlike_chan #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CANCEL_EN(1'b0)
    ) dataChan (
        .clk(clk), .resetn(resetn),
        .en(cpu_data_en), .wr(cpu_data_wr), .sel(cpu_data_sel),
        .addr(cpu_data_addr), .wdata(cpu_data_wdata),
        .flush(1'b0), .longestStall(cpu_longest_stall),
        .rdata(cpu_data_rdata), .stall(cpu_data_stall),
        .busReq(data_req), .busWr(data_wr), .busSize(data_size),
        .busAddr(data_addr), .busWdata(data_wdata), .busRdata(data_rdata),
        .busAddrOk(data_addr_ok), .busDataOk(data_data_ok)
    );

endmodule

// File: tb/tb_mips_sramlike_bridge.sv
// Directed bench for mips_sramlike_bridge: per-cycle vector tables for the
// fetch and data channels plus hand sequences for stall, flush and reset.
module tb_mips_sramlike_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpuInstEn, cpuInstStall;
    logic [31:0] cpuInstAddr, cpuInstRdata;
    logic        cpuDataEn, cpuDataWr, cpuDataStall;
    logic [3:0]  cpuDataSel;
    logic [31:0] cpuDataAddr, cpuDataWdata, cpuDataRdata;
    logic        cpuLongestStall, cpuFlush;
    logic        instReq, instWr, instAddrOk, instDataOk;
    logic [1:0]  instSize;
    logic [31:0] instAddr, instWdata, instRdata;
    logic        dataReq, dataWr, dataAddrOk, dataDataOk;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr, dataWdata, dataRdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_sramlike_bridge dut (
        .clk(clk), .resetn(resetn),
        .cpu_inst_en(cpuInstEn), .cpu_inst_addr(cpuInstAddr),
        .cpu_inst_rdata(cpuInstRdata), .cpu_inst_stall(cpuInstStall),
        .cpu_data_en(cpuDataEn), .cpu_data_wr(cpuDataWr), .cpu_data_sel(cpuDataSel),
        .cpu_data_addr(cpuDataAddr), .cpu_data_wdata(cpuDataWdata),
        .cpu_data_rdata(cpuDataRdata), .cpu_data_stall(cpuDataStall),
        .cpu_longest_stall(cpuLongestStall), .cpu_flush(cpuFlush),
        .inst_req(instReq), .inst_wr(instWr), .inst_size(instSize),
        .inst_addr(instAddr), .inst_wdata(instWdata), .inst_rdata(instRdata),
        .inst_addr_ok(instAddrOk), .inst_data_ok(instDataOk),
        .data_req(dataReq), .data_wr(dataWr), .data_size(dataSize),
        .data_addr(dataAddr), .data_wdata(dataWdata), .data_rdata(dataRdata),
        .data_addr_ok(dataAddrOk), .data_data_ok(dataDataOk)
    );

    typedef struct {
        logic        en;
        logic [31:0] pc;
        logic        aok, dok;
        logic [31:0] busRd;
        logic        lstall;
        logic        xReq, xStall;
        logic [31:0] xRd, xAddr;
    } instVec_t;

    typedef struct {
        logic        en, wr;
        logic [3:0]  sel;
        logic [31:0] addr, wdata;
        logic        aok, dok;
        logic [31:0] busRd;
        logic        lstall;
        logic        xReq, xStall, xWr;
        logic [1:0]  xSize;
        logic [31:0] xAddr, xWdata, xRd;
    } dataVec_t;

    instVec_t instVec[8];
    dataVec_t dataVec[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        cpuInstEn = 0; cpuInstAddr = '0; cpuDataEn = 0; cpuDataWr = 0; cpuDataSel = '0;
        cpuDataAddr = '0; cpuDataWdata = '0; cpuFlush = 0; cpuLongestStall = 0;
        instAddrOk = 0; instDataOk = 0; instRdata = '0;
        dataAddrOk = 0; dataDataOk = 0; dataRdata = '0;
    endtask

    initial begin
        instVec = '{
            '{1, 32'hBFC00000, 0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0},
            '{1, 32'hBFC00000, 1, 1, 32'h24010001, 0, 1, 0, 32'h24010001, 32'hBFC00000},
            '{0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h24010001, 32'hBFC00000},
            '{0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h24010001, 32'hBFC00000},
            '{1, 32'hBFC00004, 0, 0, 32'h0,        1, 0, 1, 32'h24010001, 32'hBFC00000},
            '{1, 32'hBFC00004, 1, 0, 32'h0,        1, 1, 1, 32'h24010001, 32'hBFC00004},
            '{1, 32'hBFC00004, 0, 1, 32'h3C1DBFC0, 0, 0, 0, 32'h3C1DBFC0, 32'hBFC00004},
            '{0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h3C1DBFC0, 32'hBFC00004}
        };
        dataVec = '{
            '{1, 1, 4'hF, 32'h80001000, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 1, 0, 2'd0, 32'h0,        32'h0,        32'h0},
            '{1, 1, 4'hF, 32'h80001000, 32'hDEADBEEF, 0, 0, 32'h0,        1, 1, 1, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{1, 1, 4'hF, 32'h80001000, 32'hDEADBEEF, 0, 0, 32'h0,        1, 1, 1, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{1, 1, 4'hF, 32'h80001000, 32'hDEADBEEF, 1, 0, 32'h0,        1, 1, 1, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{1, 1, 4'hF, 32'h80001000, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 1, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{1, 1, 4'hF, 32'h80001000, 32'hDEADBEEF, 0, 1, 32'h0,        0, 0, 0, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{1, 1, 4'h4, 32'h80001002, 32'h00AB0000, 0, 0, 32'h0,        1, 0, 1, 1, 2'd2, 32'h80001000, 32'hDEADBEEF, 32'h0},
            '{1, 1, 4'h4, 32'h80001002, 32'h00AB0000, 1, 1, 32'h0,        0, 1, 0, 1, 2'd0, 32'h80001002, 32'h00AB0000, 32'h0},
            '{0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 1, 2'd0, 32'h80001002, 32'h00AB0000, 32'h0},
            '{1, 0, 4'hC, 32'h80001002, 32'h0,        0, 0, 32'h0,        1, 0, 1, 1, 2'd0, 32'h80001002, 32'h00AB0000, 32'h0},
            '{1, 0, 4'hC, 32'h80001002, 32'h0,        1, 0, 32'h0,        1, 1, 1, 0, 2'd1, 32'h80001002, 32'h0,        32'h0},
            '{1, 0, 4'hC, 32'h80001002, 32'h0,        0, 1, 32'h5A5A0000, 0, 0, 0, 0, 2'd1, 32'h80001002, 32'h0,        32'h5A5A0000},
            '{0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 2'd1, 32'h80001002, 32'h0,        32'h5A5A0000},
            '{1, 1, 4'h6, 32'h80001001, 32'h11223344, 0, 0, 32'h0,        1, 0, 1, 0, 2'd1, 32'h80001002, 32'h0,        32'h5A5A0000},
            '{1, 1, 4'h6, 32'h80001001, 32'h11223344, 1, 1, 32'hCAFEF00D, 0, 1, 0, 0, 2'd2, 32'h80001001, 32'h11223344, 32'hCAFEF00D},
            '{0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 2'd2, 32'h80001001, 32'h11223344, 32'hCAFEF00D}
        };

        resetn = 0;
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.instReq", instReq, 0);
        check("reset.dataReq", dataReq, 0);
        check("reset.instStall", cpuInstStall, 0);
        check("reset.dataStall", cpuDataStall, 0);
        check("reset.instRdata", cpuInstRdata, 0);
        check("reset.dataRdata", cpuDataRdata, 0);
        check("reset.dataAddr", dataAddr, 0);
        check("reset.dataSize", dataSize, 0);
        check("reset.dataWr", dataWr, 0);
        check("reset.dataWdata", dataWdata, 0);
        check("reset.instAddr", instAddr, 0);
        check("reset.instSize", instSize, 0);
        tick();
        resetn = 1;

        for (int i = 0; i < 8; i++) begin
            cpuInstEn = instVec[i].en; cpuInstAddr = instVec[i].pc;
            instAddrOk = instVec[i].aok; instDataOk = instVec[i].dok;
            instRdata = instVec[i].busRd; cpuLongestStall = instVec[i].lstall;
            @(negedge clk);
            check($sformatf("inst[%0d].req", i), instReq, instVec[i].xReq);
            check($sformatf("inst[%0d].stall", i), cpuInstStall, instVec[i].xStall);
            check($sformatf("inst[%0d].rdata", i), cpuInstRdata, instVec[i].xRd);
            check($sformatf("inst[%0d].addr", i), instAddr, instVec[i].xAddr);
            tick();
        end
        clearInputs();

        for (int i = 0; i < 17; i++) begin
            cpuDataEn = dataVec[i].en; cpuDataWr = dataVec[i].wr; cpuDataSel = dataVec[i].sel;
            cpuDataAddr = dataVec[i].addr; cpuDataWdata = dataVec[i].wdata;
            dataAddrOk = dataVec[i].aok; dataDataOk = dataVec[i].dok;
            dataRdata = dataVec[i].busRd; cpuLongestStall = dataVec[i].lstall;
            @(negedge clk);
            check($sformatf("data[%0d].req", i), dataReq, dataVec[i].xReq);
            check($sformatf("data[%0d].stall", i), cpuDataStall, dataVec[i].xStall);
            check($sformatf("data[%0d].wr", i), dataWr, dataVec[i].xWr);
            check($sformatf("data[%0d].size", i), dataSize, dataVec[i].xSize);
            check($sformatf("data[%0d].addr", i), dataAddr, dataVec[i].xAddr);
            check($sformatf("data[%0d].wdata", i), dataWdata, dataVec[i].xWdata);
            check($sformatf("data[%0d].rdata", i), cpuDataRdata, dataVec[i].xRd);
            tick();
        end
        clearInputs();
        tick();

        // Fetch finishes early and must be held, without reissue, while the load waits.
        cpuInstEn = 1; cpuInstAddr = 32'hBFC00008;
        cpuDataEn = 1; cpuDataWr = 0; cpuDataSel = 4'hF; cpuDataAddr = 32'h80002000;
        cpuLongestStall = 1;
        @(negedge clk);
        check("hold.c0.instStall", cpuInstStall, 1);
        check("hold.c0.dataStall", cpuDataStall, 1);
        tick();
        instAddrOk = 1;
        @(negedge clk);
        check("hold.c1.instReq", instReq, 1);
        check("hold.c1.dataReq", dataReq, 1);
        tick();
        instAddrOk = 0; instDataOk = 1; instRdata = 32'h8FA20010; dataAddrOk = 1;
        @(negedge clk);
        check("hold.c2.instStall", cpuInstStall, 0);
        check("hold.c2.instRdata", cpuInstRdata, 32'h8FA20010);
        check("hold.c2.dataStall", cpuDataStall, 1);
        tick();
        instDataOk = 0; instRdata = 32'hFFFFFFFF; dataAddrOk = 0;
        for (int c = 3; c <= 6; c++) begin
            if (c == 5) begin dataDataOk = 1; dataRdata = 32'h00C0FFEE; end
            if (c == 6) begin dataDataOk = 0; dataRdata = 32'hFFFFFFFF; cpuLongestStall = 0; end
            @(negedge clk);
            check($sformatf("hold.c%0d.instReq", c), instReq, 0);
            check($sformatf("hold.c%0d.instStall", c), cpuInstStall, 0);
            check($sformatf("hold.c%0d.instRdata", c), cpuInstRdata, 32'h8FA20010);
            check($sformatf("hold.c%0d.dataStall", c), cpuDataStall, (c < 5) ? 1'b1 : 1'b0);
            if (c >= 5) check($sformatf("hold.c%0d.dataRdata", c), cpuDataRdata, 32'h00C0FFEE);
            tick();
        end
        cpuInstAddr = 32'hBFC0000C; cpuDataAddr = 32'h80002004; cpuLongestStall = 1;
        @(negedge clk);
        check("hold.c7.instStall", cpuInstStall, 1);
        check("hold.c7.dataStall", cpuDataStall, 1);
        check("hold.c7.instReq", instReq, 0);
        check("hold.c7.dataReq", dataReq, 0);
        tick();
        instAddrOk = 1; instDataOk = 1; instRdata = 32'h27BDFFE8;
        dataAddrOk = 1; dataDataOk = 1; dataRdata = 32'h00000005; cpuLongestStall = 0;
        @(negedge clk);
        check("hold.c8.instReq", instReq, 1);
        check("hold.c8.instAddr", instAddr, 32'hBFC0000C);
        check("hold.c8.instRdata", cpuInstRdata, 32'h27BDFFE8);
        check("hold.c8.dataAddr", dataAddr, 32'h80002004);
        check("hold.c8.dataRdata", cpuDataRdata, 32'h00000005);
        check("hold.c8.dataStall", cpuDataStall, 0);
        tick();
        clearInputs();
        tick();

        // Flush after the address was accepted: the late response is swallowed.
        cpuInstEn = 1; cpuInstAddr = 32'hBFC00010; cpuLongestStall = 1;
        @(negedge clk);
        check("flush.f0.instStall", cpuInstStall, 1);
        tick();
        instAddrOk = 1;
        @(negedge clk);
        check("flush.f1.instReq", instReq, 1);
        tick();
        instAddrOk = 0; cpuFlush = 1;
        @(negedge clk);
        check("flush.f2.instStall", cpuInstStall, 0);
        check("flush.f2.instReq", instReq, 0);
        tick();
        cpuFlush = 0; cpuInstAddr = 32'hBFC00380;
        for (int f = 3; f <= 5; f++) begin
            if (f == 5) begin instDataOk = 1; instRdata = 32'hDEADDEAD; end
            @(negedge clk);
            check($sformatf("flush.f%0d.instStall", f), cpuInstStall, 0);
            check($sformatf("flush.f%0d.instReq", f), instReq, 0);
            check($sformatf("flush.f%0d.instRdata", f), cpuInstRdata, 32'h27BDFFE8);
            tick();
        end
        instDataOk = 0; instRdata = '0;
        @(negedge clk);
        check("flush.f6.instStall", cpuInstStall, 1);
        check("flush.f6.instReq", instReq, 0);
        tick();
        instAddrOk = 1; instDataOk = 1; instRdata = 32'h3C1A8000; cpuLongestStall = 0;
        @(negedge clk);
        check("flush.f7.instReq", instReq, 1);
        check("flush.f7.instAddr", instAddr, 32'hBFC00380);
        check("flush.f7.instStall", cpuInstStall, 0);
        check("flush.f7.instRdata", cpuInstRdata, 32'h3C1A8000);
        tick();
        clearInputs();
        tick();

        // Flush before the address was accepted: request withdrawn at once.
        cpuInstEn = 1; cpuInstAddr = 32'hBFC00020; cpuLongestStall = 1;
        tick();
        cpuFlush = 1;
        @(negedge clk);
        check("flushA.g1.instReq", instReq, 1);
        check("flushA.g1.instStall", cpuInstStall, 0);
        tick();
        cpuFlush = 0; cpuInstAddr = 32'hBFC00380;
        @(negedge clk);
        check("flushA.g2.instReq", instReq, 0);
        check("flushA.g2.instStall", cpuInstStall, 1);
        tick();
        instAddrOk = 1; instDataOk = 1; instRdata = 32'h11110000; cpuLongestStall = 0;
        @(negedge clk);
        check("flushA.g3.instReq", instReq, 1);
        check("flushA.g3.instAddr", instAddr, 32'hBFC00380);
        check("flushA.g3.instSize", instSize, 2);
        check("flushA.g3.instWr", instWr, 0);
        check("flushA.g3.instWdata", instWdata, 0);
        check("flushA.g3.instRdata", cpuInstRdata, 32'h11110000);
        tick();
        clearInputs();
        tick();

        // Asynchronous reset while a load sits in DATA.
        cpuInstEn = 1; cpuInstAddr = 32'hBFC00040;
        cpuDataEn = 1; cpuDataSel = 4'hF; cpuDataAddr = 32'h80003000; cpuLongestStall = 1;
        tick();
        dataAddrOk = 1;
        @(negedge clk);
        check("rst.r1.dataReq", dataReq, 1);
        tick();
        dataAddrOk = 0;
        @(negedge clk);
        check("rst.r2.dataStall", cpuDataStall, 1);
        #2;
        resetn = 0;
        #1;
        check("rst.dataReq", dataReq, 0);
        check("rst.instReq", instReq, 0);
        check("rst.dataStall", cpuDataStall, 0);
        check("rst.instStall", cpuInstStall, 0);
        check("rst.dataRdata", cpuDataRdata, 0);
        check("rst.instRdata", cpuInstRdata, 0);
        check("rst.dataAddr", dataAddr, 0);
        tick();
        clearInputs();
        resetn = 1;
        cpuInstEn = 1; cpuInstAddr = 32'hBFC00000; cpuLongestStall = 1;
        @(negedge clk);
        check("rst.n0.instStall", cpuInstStall, 1);
        check("rst.n0.dataReq", dataReq, 0);
        tick();
        instAddrOk = 1; instDataOk = 1; instRdata = 32'h24010001; cpuLongestStall = 0;
        @(negedge clk);
        check("rst.n1.instReq", instReq, 1);
        check("rst.n1.instAddr", instAddr, 32'hBFC00000);
        check("rst.n1.instStall", cpuInstStall, 0);
        check("rst.n1.instRdata", cpuInstRdata, 32'h24010001);
        tick();
        clearInputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
